// File: rtl/spi_reg_pkg.sv
// rtl/spi_reg_pkg.sv - opcode constants and frame state encoding for spi_reg_bank
package spi_reg_pkg;

  localparam logic [7:0] OPC_ID       = 8'h06;
  localparam logic [7:0] OPC_LED      = 8'hA1;
  localparam logic [7:0] OPC_BURST_WR = 8'hB0;
  localparam logic [7:0] OPC_READ     = 8'hB1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ID_TX,
    ST_LED_WR,
    ST_CH_WR,
    ST_BURST_IDX,
    ST_BURST_DATA,
    ST_RD_IDX,
    ST_RD_TX,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/spi_ncs_sync.sv
// rtl/spi_ncs_sync.sv - chip-select synchroniser with edge pulses
// Two stages resynchronise ncs; the third holds the previous value for edge detection.
module spi_ncs_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ncs_i,
  output logic ncs_s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], ncs_i};
    end
  end

  assign ncs_s_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI-framed register bank with shadow/active channel and LED registers
// Writes land in shadow copies and only reach the outputs when a clean frame ends.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int         NUM_CH   = 12,
  parameter logic [7:0] CMD_BASE = 8'hA3,
  parameter logic [7:0] ID_VALUE = 8'hD4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ncs,
  input  logic                  rx_done,
  input  logic [7:0]            rx_data,
  input  logic                  tx_done,
  output logic                  tx_req,
  output logic [7:0]            tx_data,
  output logic [2:0]            led,
  output logic [NUM_CH*8-1:0]   ch_value,
  output logic                  commit,
  output logic                  frame_err
);

  localparam int         CW       = NUM_CH * 8;
  localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);
  localparam logic [3:0] NUM_CH_N = 4'(NUM_CH);

  state_e          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic            dirty_q, dirty_d;
  logic            err_q, err_d;
  logic [2:0]      led_q, led_d;
  logic [2:0]      led_sh_q, led_sh_d;
  logic [CW-1:0]   act_q, act_d;
  logic [CW-1:0]   sh_q, sh_d;
  logic            tx_req_q, tx_req_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            commit_q, commit_d;
  logic            ferr_q, ferr_d;

  logic            ncs_s, ncs_rise, ncs_fall;
  logic [7:0]      ch_off;

  spi_ncs_sync u_ncs_sync (
    .clk_i   (clk),
    .rst_i   (rst),
    .ncs_i   (ncs),
    .ncs_s_o (ncs_s),
    .rise_o  (ncs_rise),
    .fall_o  (ncs_fall)
  );

  assign ch_off = rx_data - CMD_BASE;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dirty_d   = dirty_q;
    err_d     = err_q;
    led_d     = led_q;
    led_sh_d  = led_sh_q;
    act_d     = act_q;
    sh_d      = sh_q;
    tx_req_d  = tx_req_q;
    tx_data_d = tx_data_q;
    commit_d  = 1'b0;
    ferr_d    = 1'b0;

    if (ncs_rise) begin
      // Frame end: a byte arriving in this cycle is dropped by design.
      state_d  = ST_IDLE;
      tx_req_d = 1'b0;
      if (err_q) begin
        ferr_d   = 1'b1;
        sh_d     = act_q;
        led_sh_d = led_q;
      end else if (dirty_q) begin
        commit_d = 1'b1;
        act_d    = sh_q;
        led_d    = led_sh_q;
      end
      dirty_d = 1'b0;
      err_d   = 1'b0;
    end else if (!ncs_s) begin
      case (state_q)
        ST_IDLE: if (ncs_fall) state_d = ST_CMD;
        ST_CMD: if (rx_done) begin
          if (rx_data == OPC_ID) begin
            state_d   = ST_ID_TX;
            tx_req_d  = 1'b1;
            tx_data_d = ID_VALUE;
          end else if (rx_data == OPC_LED) begin
            state_d = ST_LED_WR;
          end else if (rx_data == OPC_BURST_WR) begin
            state_d = ST_BURST_IDX;
          end else if (rx_data == OPC_READ) begin
            state_d = ST_RD_IDX;
          end else if (ch_off < NUM_CH_B) begin
            idx_d   = ch_off[3:0];
            state_d = ST_CH_WR;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
        ST_ID_TX, ST_RD_TX: if (tx_done) begin
          tx_req_d = 1'b0;
          state_d  = ST_DRAIN;
        end
        ST_LED_WR: if (rx_done) begin
          led_sh_d = rx_data[2:0];
          dirty_d  = 1'b1;
          state_d  = ST_DRAIN;
        end
        ST_CH_WR: if (rx_done) begin
          sh_d[{idx_q, 3'b000} +: 8] = rx_data;
          dirty_d = 1'b1;
          state_d = ST_DRAIN;
        end
        ST_BURST_IDX: if (rx_done) begin
          if (rx_data < NUM_CH_B) begin
            idx_d   = rx_data[3:0];
            state_d = ST_BURST_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
        ST_BURST_DATA: if (rx_done) begin
          // Running past the last channel is an error, never a wrap.
          if (idx_q == NUM_CH_N) begin
            err_d = 1'b1;
          end else begin
            sh_d[{idx_q, 3'b000} +: 8] = rx_data;
            dirty_d = 1'b1;
            idx_d   = idx_q + 4'd1;
          end
        end
        ST_RD_IDX: if (rx_done) begin
          if (rx_data < NUM_CH_B) begin
            tx_data_d = act_q[{rx_data[3:0], 3'b000} +: 8];
            tx_req_d  = 1'b1;
            state_d   = ST_RD_TX;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      dirty_q   <= 1'b0;
      err_q     <= 1'b0;
      led_q     <= '0;
      led_sh_q  <= '0;
      act_q     <= '0;
      sh_q      <= '0;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      commit_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dirty_q   <= dirty_d;
      err_q     <= err_d;
      led_q     <= led_d;
      led_sh_q  <= led_sh_d;
      act_q     <= act_d;
      sh_q      <= sh_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
      commit_q  <= commit_d;
      ferr_q    <= ferr_d;
    end
  end

  // Gating with ncs_s drops the request in the very cycle the frame ends.
  assign tx_req    = tx_req_q & ~ncs_s;
  assign tx_data   = tx_data_q;
  assign led       = led_q;
  assign ch_value  = act_q;
  assign commit    = commit_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - scoreboard bench for spi_reg_bank
module tb_spi_reg_bank;

  localparam int NUM_CH = 12;
  localparam int EV_TX = 0, EV_COMMIT = 1, EV_FERR = 2;

  logic                clk = 1'b0;
  logic                rst, ncs, rx_done, tx_done;
  logic [7:0]          rx_data;
  logic                tx_req, commit, frame_err;
  logic [7:0]          tx_data;
  logic [2:0]          led;
  logic [NUM_CH*8-1:0] ch_value;

  always #5 clk = ~clk;

  spi_reg_bank #(.NUM_CH(NUM_CH), .CMD_BASE(8'hA3), .ID_VALUE(8'hD4)) dut (
    .clk(clk), .rst(rst), .ncs(ncs), .rx_done(rx_done), .rx_data(rx_data),
    .tx_done(tx_done), .tx_req(tx_req), .tx_data(tx_data), .led(led),
    .ch_value(ch_value), .commit(commit), .frame_err(frame_err)
  );

  typedef struct {
    int           kind;
    logic [127:0] val;
  } ev_t;

  ev_t                 exp_q[$];
  int                  n_vec = 0;
  int                  n_err = 0;
  logic [2:0]          m_led = '0;
  logic [NUM_CH*8-1:0] m_ch = '0;
  logic                tx_req_prev = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int kind, input logic [127:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  function automatic logic [127:0] model_vec();
    return 128'({m_led, m_ch});
  endfunction

  task automatic see(input int kind, input logic [127:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", 128'(kind), 128'hDEAD);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 128'(kind), 128'(e.kind));
      chk("event_value", val, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_req && !tx_req_prev) see(EV_TX, 128'(tx_data));
      if (commit)    see(EV_COMMIT, 128'({led, ch_value}));
      if (frame_err) see(EV_FERR, 128'({led, ch_value}));
    end
    tx_req_prev = tx_req;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick(2);
  endtask

  task automatic frame_start();
    ncs = 1'b0;
    tick(5);
  endtask

  task automatic frame_end();
    ncs = 1'b1;
    tick(4);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    chk("events_drained", 128'(exp_q.size()), 128'd0);
    tick(2);
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ncs = 1'b1; rx_done = 1'b0; tx_done = 1'b0; rx_data = '0;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("rst_tx_req", 128'(tx_req), 128'd0);
    chk("rst_tx_data", 128'(tx_data), 128'd0);
    chk("rst_led", 128'(led), 128'd0);
    chk("rst_ch_value", 128'(ch_value), 128'd0);
    chk("rst_commit", 128'(commit), 128'd0);
    chk("rst_frame_err", 128'(frame_err), 128'd0);

    // ID read: request held for 5 cycles, dropped right after tx_done
    frame_start();
    push(EV_TX, 128'h D4);
    send(8'h06);
    for (int i = 0; i < 5; i++) begin
      chk("id_tx_req_held", 128'(tx_req), 128'd1);
      tick();
    end
    pulse_tx_done();
    chk("id_tx_req_drop", 128'(tx_req), 128'd0);
    frame_end();

    frame_start();
    send(8'hA1); send(8'h05);
    m_led = 3'd5;
    push(EV_COMMIT, model_vec());
    frame_end();

    // Channel 2 single write stays invisible until commit
    frame_start();
    send(8'hA5); send(8'h7F);
    chk("ch2_before_commit", 128'(ch_value[23:16]), 128'd0);
    m_ch[23:16] = 8'h7F;
    push(EV_COMMIT, model_vec());
    frame_end();
    chk("ch_after_commit", 128'(ch_value), 128'(m_ch));

    // Burst overrunning the last channel
    frame_start();
    send(8'hB0); send(8'h0A); send(8'h11); send(8'h22); send(8'h33);
    push(EV_FERR, model_vec());
    frame_end();
    chk("ch_after_burst_err", 128'(ch_value), 128'(m_ch));

    // Shadow must have been restored: ch10/11 stay zero on this commit
    frame_start();
    send(8'hA3); send(8'h44);
    m_ch[7:0] = 8'h44;
    push(EV_COMMIT, model_vec());
    frame_end();

    frame_start();
    push(EV_TX, 128'h7F);
    send(8'hB1); send(8'h02);
    tick(3);
    pulse_tx_done();
    chk("rd_tx_req_drop", 128'(tx_req), 128'd0);
    frame_end();

    frame_start();
    send(8'hB1); send(8'h0C);
    push(EV_FERR, model_vec());
    frame_end();

    frame_start();
    send(8'h55); send(8'h12);
    push(EV_FERR, model_vec());
    frame_end();

    frame_start();
    send(8'hB0); send(8'h09); send(8'h01); send(8'h02); send(8'h03);
    m_ch[79:72] = 8'h01; m_ch[87:80] = 8'h02; m_ch[95:88] = 8'h03;
    push(EV_COMMIT, model_vec());
    frame_end();

    // Chip select released mid ID transmit
    frame_start();
    push(EV_TX, 128'hD4);
    send(8'h06);
    tick(3);
    frame_end();
    chk("abort_tx_req", 128'(tx_req), 128'd0);

    // Reset mid burst clears everything and leaves nothing to commit
    frame_start();
    send(8'hB0); send(8'h00); send(8'hAA);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
    m_ch = '0; m_led = '0;
    chk("rst_mid_tx_req", 128'(tx_req), 128'd0);
    chk("rst_mid_ch_led", 128'({led, ch_value}), 128'd0);
    chk("rst_mid_pulses", 128'({commit, frame_err}), 128'd0);
    tick(4);
    frame_end();

    frame_start();
    send(8'hA3); send(8'h5A);
    m_ch[7:0] = 8'h5A;
    push(EV_COMMIT, model_vec());
    frame_end();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
